// File: rtl/fib_pkg.sv
// Shared widths and record types for the name-lookup tree levels.
package fib_pkg;

    localparam int FIB_WORD_SIZE    = 64;
    localparam int FIB_POINTER_SIZE = 16;
    localparam int FIB_TAG_SIZE     = 8;

    typedef struct packed {
        logic [FIB_WORD_SIZE-1:0]    word;
        logic [FIB_POINTER_SIZE-1:0] lp;
        logic [FIB_POINTER_SIZE-1:0] rp;
        logic                        lp_valid;
        logic                        rp_valid;
        logic                        entry_valid;
    } fib_entry_t;

    typedef struct packed {
        logic [FIB_POINTER_SIZE-1:0] next_ptr;
        logic                        match;
        logic                        no_child;
        logic                        err;
    } fib_result_t;

endpackage

// File: rtl/fib_level_mem.sv
// Node table for one level: word/pointer storage plus entry-valid flops, one write
// port and one registered, enable-gated read port (read-before-write on collisions).
module fib_level_mem
    import fib_pkg::*;
#(
    parameter int MEM_SIZE     = 1024,
    parameter int POINTER_SIZE = FIB_POINTER_SIZE
) (
    input  logic                    clk_in,
    input  logic                    rst_n_in,
    input  logic                    wr_en_in,
    input  logic [POINTER_SIZE-1:0] wr_addr_in,
    input  fib_entry_t              wr_entry_in,
    input  logic                    rd_en_in,
    input  logic [POINTER_SIZE-1:0] rd_addr_in,
    output fib_entry_t              rd_entry_out
);

    localparam int AW = (MEM_SIZE > 1) ? $clog2(MEM_SIZE) : 1;
    localparam logic [POINTER_SIZE:0] LIMIT = (POINTER_SIZE + 1)'(MEM_SIZE);

    logic [FIB_WORD_SIZE-1:0]    word_mem [MEM_SIZE];
    logic [FIB_POINTER_SIZE-1:0] lp_mem   [MEM_SIZE];
    logic [FIB_POINTER_SIZE-1:0] rp_mem   [MEM_SIZE];
    logic [MEM_SIZE-1:0]         lpv_mem;
    logic [MEM_SIZE-1:0]         rpv_mem;
    logic [MEM_SIZE-1:0]         ev_mem;

    logic                        wr_ok;
    logic                        rd_ok;
    logic [AW-1:0]               wr_idx;
    logic [AW-1:0]               rd_idx;

    logic [FIB_WORD_SIZE-1:0]    rd_word_p1;
    logic [FIB_POINTER_SIZE-1:0] rd_lp_p1;
    logic [FIB_POINTER_SIZE-1:0] rd_rp_p1;
    logic                        rd_lpv_p1;
    logic                        rd_rpv_p1;
    logic                        rd_ev_p1;

    assign wr_ok  = ({1'b0, wr_addr_in} < LIMIT);
    assign rd_ok  = ({1'b0, rd_addr_in} < LIMIT);
    assign wr_idx = wr_addr_in[AW-1:0];
    assign rd_idx = rd_addr_in[AW-1:0];

    always_ff @(posedge clk_in) begin
        if (wr_en_in && wr_ok) begin
            word_mem[wr_idx] <= wr_entry_in.word;
            lp_mem[wr_idx]   <= wr_entry_in.lp;
            rp_mem[wr_idx]   <= wr_entry_in.rp;
            lpv_mem[wr_idx]  <= wr_entry_in.lp_valid;
            rpv_mem[wr_idx]  <= wr_entry_in.rp_valid;
        end
        if (rd_en_in) begin
            rd_word_p1 <= word_mem[rd_idx];
            rd_lp_p1   <= lp_mem[rd_idx];
            rd_rp_p1   <= rp_mem[rd_idx];
            rd_lpv_p1  <= lpv_mem[rd_idx];
            rd_rpv_p1  <= rpv_mem[rd_idx];
        end
    end

    // Out-of-range reads report an invalid entry, so the stage only checks one bit.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            ev_mem   <= '0;
            rd_ev_p1 <= 1'b0;
        end else begin
            if (wr_en_in && wr_ok) begin
                ev_mem[wr_idx] <= wr_entry_in.entry_valid;
            end
            if (rd_en_in) begin
                rd_ev_p1 <= rd_ok && ev_mem[rd_idx];
            end
        end
    end

    assign rd_entry_out = '{word:        rd_word_p1,
                            lp:          rd_lp_p1,
                            rp:          rd_rp_p1,
                            lp_valid:    rd_lpv_p1,
                            rp_valid:    rd_rpv_p1,
                            entry_valid: rd_ev_p1};

endmodule

// File: rtl/fib_level_stage.sv
// One pipelined level of the name-lookup tree: table read in S1, key compare in S2,
// stall-all valid/ready handshake, runtime table writes.
module fib_level_stage
    import fib_pkg::*;
#(
    parameter int WORD_SIZE    = FIB_WORD_SIZE,
    parameter int POINTER_SIZE = FIB_POINTER_SIZE,
    parameter int MEM_SIZE     = 1024,
    parameter int TAG_SIZE     = FIB_TAG_SIZE,
    parameter int LEVEL_ID     = 1
) (
    input  logic                    clk_in,
    input  logic                    rst_n_in,
    input  logic                    in_valid_in,
    output logic                    in_ready_out,
    input  logic [POINTER_SIZE-1:0] address_in,
    input  logic [WORD_SIZE-1:0]    lookup_cont_in,
    input  logic [TAG_SIZE-1:0]     tag_in,
    output logic                    out_valid_out,
    input  logic                    out_ready_in,
    output logic [POINTER_SIZE-1:0] next_pointer_out,
    output logic                    is_match_out,
    output logic                    no_child_out,
    output logic                    err_out,
    output logic [7:0]              err_level_out,
    output logic [TAG_SIZE-1:0]     tag_out,
    input  logic                    wr_en_in,
    input  logic [POINTER_SIZE-1:0] wr_addr_in,
    input  logic [WORD_SIZE-1:0]    wr_word_in,
    input  logic [POINTER_SIZE-1:0] wr_lp_in,
    input  logic [POINTER_SIZE-1:0] wr_rp_in,
    input  logic                    wr_lp_valid_in,
    input  logic                    wr_rp_valid_in,
    input  logic                    wr_entry_valid_in
);

    localparam logic [7:0] LEVEL_TAG = 8'(LEVEL_ID);

    logic                 advance;
    fib_entry_t           wr_entry;
    fib_entry_t           entry_p1;
    logic                 vld_p1;
    logic [WORD_SIZE-1:0] key_p1;
    logic [TAG_SIZE-1:0]  tag_p1;
    fib_result_t          res_p2;
    logic [TAG_SIZE-1:0]  tag_p2;

    function automatic fib_result_t compare_node(input logic [WORD_SIZE-1:0] key,
                                                 input fib_entry_t           e);
        fib_result_t r;
        r = '0;
        if (!e.entry_valid) begin
            r.err      = 1'b1;
            r.no_child = 1'b1;
        end else if (key == e.word) begin
            r.match = 1'b1;
        end else if (key < e.word) begin
            r.next_ptr = e.lp_valid ? e.lp : '0;
            r.no_child = !e.lp_valid;
        end else begin
            r.next_ptr = e.rp_valid ? e.rp : '0;
            r.no_child = !e.rp_valid;
        end
        return r;
    endfunction

    assign advance      = !out_valid_out || out_ready_in;
    assign in_ready_out = advance;

    assign wr_entry = '{word:        wr_word_in,
                        lp:          wr_lp_in,
                        rp:          wr_rp_in,
                        lp_valid:    wr_lp_valid_in,
                        rp_valid:    wr_rp_valid_in,
                        entry_valid: wr_entry_valid_in};

    // S1: table read (inside the memory) plus key and tag capture
    fib_level_mem #(
        .MEM_SIZE     (MEM_SIZE),
        .POINTER_SIZE (POINTER_SIZE)
    ) u_mem (
        .clk_in       (clk_in),
        .rst_n_in     (rst_n_in),
        .wr_en_in     (wr_en_in),
        .wr_addr_in   (wr_addr_in),
        .wr_entry_in  (wr_entry),
        .rd_en_in     (advance),
        .rd_addr_in   (address_in),
        .rd_entry_out (entry_p1)
    );

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            vld_p1 <= 1'b0;
        end else if (advance) begin
            vld_p1 <= in_valid_in;
        end
    end

    always_ff @(posedge clk_in) begin
        if (advance) begin
            key_p1 <= lookup_cont_in;
            tag_p1 <= tag_in;
        end
    end

    // S2: compare and register the result; bubbles clear the outputs
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            out_valid_out <= 1'b0;
            res_p2        <= '0;
            tag_p2        <= '0;
        end else if (advance) begin
            out_valid_out <= vld_p1;
            res_p2        <= vld_p1 ? compare_node(key_p1, entry_p1) : '0;
            tag_p2        <= vld_p1 ? tag_p1 : '0;
        end
    end

    assign next_pointer_out = res_p2.next_ptr;
    assign is_match_out     = res_p2.match;
    assign no_child_out     = res_p2.no_child;
    assign err_out          = res_p2.err;
    assign err_level_out    = res_p2.err ? LEVEL_TAG : 8'd0;
    assign tag_out          = tag_p2;

endmodule

// File: tb/tb_fib_level_stage.sv
// Bench for fib_level_stage: directed vector table, hand-written handshake/reset
// sequences, and randomized traffic against a queue-based reference model.
module tb_fib_level_stage;

    localparam int MEM = 16;
    localparam int LVL = 5;

    logic        clk_in;
    logic        rst_n_in;
    logic        in_valid_in;
    logic        in_ready_out;
    logic [15:0] address_in;
    logic [63:0] lookup_cont_in;
    logic [7:0]  tag_in;
    logic        out_valid_out;
    logic        out_ready_in;
    logic [15:0] next_pointer_out;
    logic        is_match_out;
    logic        no_child_out;
    logic        err_out;
    logic [7:0]  err_level_out;
    logic [7:0]  tag_out;
    logic        wr_en_in;
    logic [15:0] wr_addr_in;
    logic [63:0] wr_word_in;
    logic [15:0] wr_lp_in;
    logic [15:0] wr_rp_in;
    logic        wr_lp_valid_in;
    logic        wr_rp_valid_in;
    logic        wr_entry_valid_in;

    fib_level_stage #(
        .MEM_SIZE (MEM),
        .LEVEL_ID (LVL)
    ) dut (
        .clk_in            (clk_in),
        .rst_n_in          (rst_n_in),
        .in_valid_in       (in_valid_in),
        .in_ready_out      (in_ready_out),
        .address_in        (address_in),
        .lookup_cont_in    (lookup_cont_in),
        .tag_in            (tag_in),
        .out_valid_out     (out_valid_out),
        .out_ready_in      (out_ready_in),
        .next_pointer_out  (next_pointer_out),
        .is_match_out      (is_match_out),
        .no_child_out      (no_child_out),
        .err_out           (err_out),
        .err_level_out     (err_level_out),
        .tag_out           (tag_out),
        .wr_en_in          (wr_en_in),
        .wr_addr_in        (wr_addr_in),
        .wr_word_in        (wr_word_in),
        .wr_lp_in          (wr_lp_in),
        .wr_rp_in          (wr_rp_in),
        .wr_lp_valid_in    (wr_lp_valid_in),
        .wr_rp_valid_in    (wr_rp_valid_in),
        .wr_entry_valid_in (wr_entry_valid_in)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: the table as plain arrays, in-flight lookups as a queue of
    // results computed when the request is accepted.
    typedef struct {
        logic [15:0] ptr;
        logic        match;
        logic        nc;
        logic        err;
        logic [7:0]  tag;
    } res_t;

    logic [63:0] m_word [MEM];
    logic [15:0] m_lp   [MEM];
    logic [15:0] m_rp   [MEM];
    logic        m_lpv  [MEM];
    logic        m_rpv  [MEM];
    logic        m_ev   [MEM];
    res_t        exp_q  [$];
    logic [7:0]  seen_q [$];

    function automatic res_t model_lookup(input logic [15:0] addr, input logic [63:0] key,
                                          input logic [7:0] tag);
        res_t r;
        logic [3:0] a;
        logic present;
        r.ptr = 16'd0; r.match = 1'b0; r.nc = 1'b0; r.err = 1'b0; r.tag = tag;
        a = addr[3:0];
        if (addr >= 16'(MEM) || !m_ev[a]) begin
            r.err = 1'b1;
            r.nc  = 1'b1;
        end else if (key == m_word[a]) begin
            r.match = 1'b1;
        end else begin
            present = (key < m_word[a]) ? m_lpv[a] : m_rpv[a];
            r.nc    = !present;
            if (present) r.ptr = (key < m_word[a]) ? m_lp[a] : m_rp[a];
        end
        return r;
    endfunction

    always @(negedge clk_in) begin
        res_t e;
        logic [3:0] wa;
        if (!rst_n_in) begin
            exp_q.delete();
            m_ev = '{default: 1'b0};
        end else begin
            if (out_valid_out && out_ready_in) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_unexpected: got result tag 0x%0h, required no output", tag_out);
                end else begin
                    e = exp_q.pop_front();
                    chk("sb_ptr", 64'(next_pointer_out), 64'(e.ptr));
                    chk("sb_match", 64'(is_match_out), 64'(e.match));
                    chk("sb_no_child", 64'(no_child_out), 64'(e.nc));
                    chk("sb_err", 64'(err_out), 64'(e.err));
                    chk("sb_err_level", 64'(err_level_out), e.err ? 64'(LVL) : 64'd0);
                    chk("sb_tag", 64'(tag_out), 64'(e.tag));
                    seen_q.push_back(tag_out);
                end
            end
            if (in_valid_in && in_ready_out)
                exp_q.push_back(model_lookup(address_in, lookup_cont_in, tag_in));
            if (wr_en_in && wr_addr_in < 16'(MEM)) begin
                wa         = wr_addr_in[3:0];
                m_word[wa] = wr_word_in;
                m_lp[wa]   = wr_lp_in;
                m_rp[wa]   = wr_rp_in;
                m_lpv[wa]  = wr_lp_valid_in;
                m_rpv[wa]  = wr_rp_valid_in;
                m_ev[wa]   = wr_entry_valid_in;
            end
        end
    end

    typedef struct {
        logic [15:0] addr;
        logic [63:0] key;
        logic [7:0]  tag;
        logic [15:0] ptr;
        logic        match;
        logic        nc;
        logic        err;
    } vec_t;

    vec_t vecs [11];

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic do_write(input logic [15:0] a, input logic [63:0] w, input logic [15:0] lp,
                            input logic [15:0] rp, input logic lpv, input logic rpv,
                            input logic ev);
        wr_en_in = 1'b1; wr_addr_in = a; wr_word_in = w; wr_lp_in = lp; wr_rp_in = rp;
        wr_lp_valid_in = lpv; wr_rp_valid_in = rpv; wr_entry_valid_in = ev;
        tick();
        wr_en_in = 1'b0;
    endtask

    task automatic apply_vec(input int i, input vec_t v);
        address_in = v.addr; lookup_cont_in = v.key; tag_in = v.tag; in_valid_in = 1'b1;
        #1;
        chk($sformatf("v%0d_in_ready", i), 64'(in_ready_out), 64'd1);
        tick();
        in_valid_in = 1'b0;
        chk($sformatf("v%0d_early_valid", i), 64'(out_valid_out), 64'd0);
        tick();
        chk($sformatf("v%0d_valid", i), 64'(out_valid_out), 64'd1);
        chk($sformatf("v%0d_ptr", i), 64'(next_pointer_out), 64'(v.ptr));
        chk($sformatf("v%0d_match", i), 64'(is_match_out), 64'(v.match));
        chk($sformatf("v%0d_no_child", i), 64'(no_child_out), 64'(v.nc));
        chk($sformatf("v%0d_err", i), 64'(err_out), 64'(v.err));
        chk($sformatf("v%0d_err_level", i), 64'(err_level_out), v.err ? 64'(LVL) : 64'd0);
        chk($sformatf("v%0d_tag", i), 64'(tag_out), 64'(v.tag));
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation still running, required to finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int stall;
        bit fresh;
        bit acc;
        logic [15:0] h_ptr;
        logic [7:0]  h_tag;
        logic        h_match;
        logic [63:0] bp_keys [4];
        int n_out;
        int n_err;

        vecs[0]  = '{16'd3,      64'h50, 8'hA1, 16'd0, 1'b1, 1'b0, 1'b0};
        vecs[1]  = '{16'd3,      64'h10, 8'h02, 16'd7, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{16'd3,      64'h90, 8'h03, 16'd9, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{16'd5,      64'h50, 8'h04, 16'd0, 1'b0, 1'b1, 1'b1};
        vecs[4]  = '{16'(MEM),   64'h50, 8'h05, 16'd0, 1'b0, 1'b1, 1'b1};
        vecs[5]  = '{16'hFFFF,   64'h50, 8'h06, 16'd0, 1'b0, 1'b1, 1'b1};
        vecs[6]  = '{16'd0,      64'h50, 8'h07, 16'd0, 1'b0, 1'b1, 1'b1};
        vecs[7]  = '{16'd3,      64'h90, 8'h08, 16'd0, 1'b0, 1'b1, 1'b0};
        vecs[8]  = '{16'd3,      64'h10, 8'h09, 16'd7, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{16'd3,      64'h10, 8'h0A, 16'd0, 1'b0, 1'b1, 1'b0};
        vecs[10] = '{16'd3,      64'h50, 8'h0B, 16'd0, 1'b1, 1'b0, 1'b0};

        rst_n_in = 1'b0; in_valid_in = 1'b0; address_in = '0; lookup_cont_in = '0;
        tag_in = '0; out_ready_in = 1'b1; wr_en_in = 1'b0; wr_addr_in = '0;
        wr_word_in = '0; wr_lp_in = '0; wr_rp_in = '0; wr_lp_valid_in = 1'b0;
        wr_rp_valid_in = 1'b0; wr_entry_valid_in = 1'b0;

        #12;
        chk("rst_out_valid", 64'(out_valid_out), 64'd0);
        chk("rst_ptr", 64'(next_pointer_out), 64'd0);
        chk("rst_match", 64'(is_match_out), 64'd0);
        chk("rst_no_child", 64'(no_child_out), 64'd0);
        chk("rst_err", 64'(err_out), 64'd0);
        chk("rst_err_level", 64'(err_level_out), 64'd0);
        chk("rst_tag", 64'(tag_out), 64'd0);
        chk("rst_in_ready", 64'(in_ready_out), 64'd1);
        tick();
        rst_n_in = 1'b1;
        tick();

        // A write just past the table must be dropped, not alias onto entry 0.
        do_write(16'(MEM), 64'h50, 16'd1, 16'd2, 1'b1, 1'b1, 1'b1);
        do_write(16'd3, 64'h50, 16'd7, 16'd9, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 11; i++) begin
            if (i == 7) do_write(16'd3, 64'h50, 16'd7, 16'd9, 1'b1, 1'b0, 1'b1);
            if (i == 9) do_write(16'd3, 64'h50, 16'd7, 16'd9, 1'b0, 1'b1, 1'b1);
            apply_vec(i, vecs[i]);
        end

        // Back-to-back lookups with three cycles of downstream backpressure.
        do_write(16'd3, 64'h50, 16'd7, 16'd9, 1'b1, 1'b1, 1'b1);
        bp_keys[0] = 64'h50; bp_keys[1] = 64'h10; bp_keys[2] = 64'h90; bp_keys[3] = 64'h50;
        seen_q.delete();
        k = 1; stall = -1; h_ptr = '0; h_tag = '0; h_match = 1'b0;
        for (int cyc = 0; cyc < 40 && seen_q.size() < 4; cyc++) begin
            in_valid_in    = (k <= 4);
            address_in     = 16'd3;
            lookup_cont_in = bp_keys[(k - 1) % 4];
            tag_in         = 8'(k);
            fresh = 1'b0;
            if (stall == -1 && out_valid_out) begin
                stall = 3; fresh = 1'b1;
                h_ptr = next_pointer_out; h_tag = tag_out; h_match = is_match_out;
                chk("bp_first_tag", 64'(h_tag), 64'd1);
            end
            out_ready_in = !(stall > 0);
            #1;
            if (stall > 0) begin
                chk("bp_in_ready_low", 64'(in_ready_out), 64'd0);
                if (!fresh) begin
                    chk("bp_hold_valid", 64'(out_valid_out), 64'd1);
                    chk("bp_hold_tag", 64'(tag_out), 64'(h_tag));
                    chk("bp_hold_ptr", 64'(next_pointer_out), 64'(h_ptr));
                    chk("bp_hold_match", 64'(is_match_out), 64'(h_match));
                end
                stall--;
            end
            acc = in_valid_in && in_ready_out;
            tick();
            if (acc) k++;
        end
        in_valid_in = 1'b0; out_ready_in = 1'b1;
        repeat (3) tick();
        chk("bp_result_count", 64'(seen_q.size()), 64'd4);
        for (int i = 0; i < 4 && i < seen_q.size(); i++)
            chk($sformatf("bp_order_%0d", i), 64'(seen_q[i]), 64'(i + 1));

        // Write and lookup of the same entry on the same edge: old contents win.
        wr_en_in = 1'b1; wr_addr_in = 16'd3; wr_word_in = 64'h60; wr_lp_in = 16'd7;
        wr_rp_in = 16'd9; wr_lp_valid_in = 1'b1; wr_rp_valid_in = 1'b1; wr_entry_valid_in = 1'b1;
        in_valid_in = 1'b1; address_in = 16'd3; lookup_cont_in = 64'h60; tag_in = 8'h77;
        tick();
        wr_en_in = 1'b0; in_valid_in = 1'b0;
        tick();
        chk("rbw_valid", 64'(out_valid_out), 64'd1);
        chk("rbw_ptr", 64'(next_pointer_out), 64'd9);
        chk("rbw_match", 64'(is_match_out), 64'd0);
        chk("rbw_tag", 64'(tag_out), 64'h77);
        apply_vec(11, '{16'd3, 64'h60, 8'h78, 16'd0, 1'b1, 1'b0, 1'b0});

        // Reset with two lookups in flight.
        in_valid_in = 1'b1; address_in = 16'd3; lookup_cont_in = 64'h60; tag_in = 8'h31;
        tick();
        tag_in = 8'h32;
        tick();
        in_valid_in = 1'b0;
        chk("inflight_valid", 64'(out_valid_out), 64'd1);
        rst_n_in = 1'b0;
        #1;
        chk("mid_rst_valid", 64'(out_valid_out), 64'd0);
        chk("mid_rst_tag", 64'(tag_out), 64'd0);
        chk("mid_rst_match", 64'(is_match_out), 64'd0);
        tick();
        tick();
        rst_n_in = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("post_rst_idle_%0d", i), 64'(out_valid_out), 64'd0);
        end
        n_out = 0; n_err = 0;
        for (int i = 0; i < 20; i++) begin
            in_valid_in = (i < MEM);
            address_in = 16'(i);
            lookup_cont_in = 64'h60;
            tag_in = 8'(8'h40 + i);
            #1;
            if (out_valid_out) begin
                n_out++;
                if (err_out) n_err++;
            end
            tick();
        end
        in_valid_in = 1'b0;
        chk("post_rst_results", 64'(n_out), 64'(MEM));
        chk("post_rst_all_err", 64'(n_err), 64'(MEM));

        // Randomized traffic, writes and backpressure against the model.
        for (int i = 0; i < 400; i++) begin
            wr_en_in          = ($urandom % 4 == 0);
            wr_addr_in        = 16'($urandom_range(0, MEM + 1));
            wr_word_in        = 64'($urandom_range(0, 7));
            wr_lp_in          = 16'($urandom);
            wr_rp_in          = 16'($urandom);
            wr_lp_valid_in    = ($urandom % 2 == 0);
            wr_rp_valid_in    = ($urandom % 2 == 0);
            wr_entry_valid_in = ($urandom % 5 != 0);
            in_valid_in       = ($urandom % 3 != 0);
            address_in        = 16'($urandom_range(0, MEM + 1));
            lookup_cont_in    = 64'($urandom_range(0, 8));
            tag_in            = 8'($urandom);
            out_ready_in      = ($urandom % 4 != 0);
            tick();
        end
        wr_en_in = 1'b0; in_valid_in = 1'b0; out_ready_in = 1'b1;
        repeat (5) tick();
        chk("rand_drained", 64'(exp_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
